// File: rtl/mc_config_loader.sv
// Parses HEADER + 12 payload bytes + XOR checksum into shadow registers and commits them to the outputs one cycle
// after a good checksum, with a one-cycle core_start/frame_ok pulse; in_ready drops only in that commit cycle.
module mc_config_loader #(
  parameter int          WIDTH   = 10,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int          TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] num_of_iterations,
  output logic [WIDTH-1:0] seed_1,
  output logic [WIDTH-1:0] seed_2,
  output logic [WIDTH:0]   seed_3,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             core_start,
  output logic             frame_ok,
  output logic             frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_APPLY} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [7:0]       r_xor;
  logic [TW-1:0]    r_idle;
  logic [11:0][7:0] r_shadow;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_iter;
  logic [WIDTH-1:0] r_seed_1;
  logic [WIDTH-1:0] r_seed_2;
  logic [WIDTH:0]   r_seed_3;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_core_start;
  logic             r_frame_ok;
  logic             r_frame_err;

  logic             w_xfer;
  logic             w_in_frame;
  logic [TW-1:0]    w_idle_nxt;
  logic             w_timeout;
  logic [15:0]      w_f0, w_f1, w_f2, w_f3, w_f4, w_f5;

  assign w_xfer     = in_valid & r_in_ready;
  assign w_in_frame = (r_state == S_PAYLOAD) || (r_state == S_CHECK);
  // Saturating idle count; the frame aborts on the edge where it would reach TIMEOUT.
  assign w_idle_nxt = (r_idle == TW'(TIMEOUT)) ? r_idle : r_idle + TW'(1);
  assign w_timeout  = w_in_frame && !w_xfer && (w_idle_nxt == TW'(TIMEOUT));

  // Fields are carried LSB byte first.
  assign w_f0 = {r_shadow[1],  r_shadow[0]};
  assign w_f1 = {r_shadow[3],  r_shadow[2]};
  assign w_f2 = {r_shadow[5],  r_shadow[4]};
  assign w_f3 = {r_shadow[7],  r_shadow[6]};
  assign w_f4 = {r_shadow[9],  r_shadow[8]};
  assign w_f5 = {r_shadow[11], r_shadow[10]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_xor        <= '0;
      r_idle       <= '0;
      r_shadow     <= '0;
      r_in_ready   <= 1'b1;
      r_iter       <= '0;
      r_seed_1     <= '0;
      r_seed_2     <= '0;
      r_seed_3     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_core_start <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && (in_data == HEADER)) begin
            r_state <= S_PAYLOAD;
            r_cnt   <= '0;
            r_xor   <= '0;
            r_idle  <= '0;
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_shadow[r_cnt] <= in_data;
            r_xor           <= r_xor ^ in_data;
            r_idle          <= '0;
            if (r_cnt == 4'd11) begin
              r_state <= S_CHECK;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
            r_shadow    <= '0;
            r_idle      <= '0;
          end else begin
            r_idle <= w_idle_nxt;
          end
        end
        S_CHECK: begin
          if (w_xfer) begin
            r_idle <= '0;
            if (in_data == r_xor) begin
              r_state    <= S_APPLY;
              r_in_ready <= 1'b0;
            end else begin
              r_state     <= S_IDLE;
              r_frame_err <= 1'b1;
              r_shadow    <= '0;
            end
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
            r_shadow    <= '0;
            r_idle      <= '0;
          end else begin
            r_idle <= w_idle_nxt;
          end
        end
        S_APPLY: begin
          r_iter       <= w_f0[WIDTH-1:0];
          r_seed_1     <= w_f1[WIDTH-1:0];
          r_seed_2     <= w_f2[WIDTH-1:0];
          r_seed_3     <= w_f3[WIDTH:0];
          r_a          <= w_f4[WIDTH-1:0];
          r_b          <= w_f5[WIDTH-1:0];
          r_core_start <= 1'b1;
          r_frame_ok   <= 1'b1;
          r_in_ready   <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready          = r_in_ready;
  assign num_of_iterations = r_iter;
  assign seed_1            = r_seed_1;
  assign seed_2            = r_seed_2;
  assign seed_3            = r_seed_3;
  assign a                 = r_a;
  assign b                 = r_b;
  assign core_start        = r_core_start;
  assign frame_ok          = r_frame_ok;
  assign frame_err         = r_frame_err;

endmodule

// File: tb/tb_mc_config_loader.sv
// Directed bench for mc_config_loader: table of frames with hand-computed results plus timeout/reset/back-to-back sequences.
module tb_mc_config_loader;
  localparam int         TIMEOUT = 1000;
  localparam logic [7:0] HDR     = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  num_of_iterations, seed_1, seed_2, a, b;
  logic [10:0] seed_3;
  logic        core_start, frame_ok, frame_err;

  mc_config_loader #(.WIDTH(10), .HEADER(HDR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .num_of_iterations(num_of_iterations), .seed_1(seed_1), .seed_2(seed_2), .seed_3(seed_3),
    .a(a), .b(b), .core_start(core_start), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit               garbage;
    logic [5:0][15:0] f;
    logic [7:0]       flip;
    bit               ok;
    logic [9:0]       it, s1, s2;
    logic [10:0]      s3;
    logic [9:0]       ea, eb;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int oks    = 0;
  int lows   = 0;
  int exp_commits = 0;

  // Previous-cycle values seen at each rising edge.
  always @(posedge clk) begin
    if (core_start) starts++;
    if (frame_ok) oks++;
    if (!rst && !in_ready) lows++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0][15:0] mkf(input logic [15:0] it, s1, s2, s3, fa, fb);
    return {fb, fa, s3, s2, s1, it};
  endfunction

  task automatic send_byte(input logic [7:0] bt);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = bt;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [5:0][15:0] f, input logic [7:0] flip);
    logic [7:0]  x;
    logic [15:0] w;
    logic [7:0]  bt;
    x = 8'h00;
    send_byte(HDR);
    for (int i = 0; i < 12; i++) begin
      w  = f[i/2];
      bt = (i % 2 == 0) ? w[7:0] : w[15:8];
      x  = x ^ bt;
      send_byte(bt);
    end
    send_byte(x ^ flip);
  endtask

  task automatic chk_outs(input string tag, input logic [9:0] it, s1, s2, input logic [10:0] s3,
                          input logic [9:0] ea, eb);
    chk({tag, "_iter"}, 32'(num_of_iterations), 32'(it));
    chk({tag, "_seed1"}, 32'(seed_1), 32'(s1));
    chk({tag, "_seed2"}, 32'(seed_2), 32'(s2));
    chk({tag, "_seed3"}, 32'(seed_3), 32'(s3));
    chk({tag, "_a"}, 32'(a), 32'(ea));
    chk({tag, "_b"}, 32'(b), 32'(eb));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int st0;
    st0 = starts;
    if (v.garbage) begin
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h12);
    end
    send_frame(v.f, v.flip);
    // Cycle N..N+1: checksum just taken.
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_err_N"}, {31'd0, frame_err}, {31'd0, !v.ok});
    chk({tag, "_start_N"}, {31'd0, core_start}, 32'd0);
    chk({tag, "_rdy_N"}, {31'd0, in_ready}, {31'd0, !v.ok});
    // Cycle N+1..N+2: commit visible.
    @(negedge clk);
    chk({tag, "_start_N1"}, {31'd0, core_start}, {31'd0, v.ok});
    chk({tag, "_ok_N1"}, {31'd0, frame_ok}, {31'd0, v.ok});
    chk({tag, "_err_N1"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_rdy_N1"}, {31'd0, in_ready}, 32'd1);
    chk_outs(tag, v.it, v.s1, v.s2, v.s3, v.ea, v.eb);
    @(negedge clk);
    chk({tag, "_start_cnt"}, 32'(starts - st0), v.ok ? 32'd1 : 32'd0);
    if (v.ok) exp_commits++;
  endtask

  vec_t vecs[6];

  initial begin
    int k;
    logic [5:0][15:0] fp;
    logic [15:0] w;

    vecs[0] = '{1'b0, mkf(16'd1000, 16'd20, 16'd10, 16'd5, 16'd1, 16'd1), 8'h00, 1'b1,
                10'd1000, 10'd20, 10'd10, 11'd5, 10'd1, 10'd1};
    vecs[1] = '{1'b0, mkf(16'd1000, 16'd20, 16'd10, 16'd5, 16'd1, 16'd1), 8'h01, 1'b0,
                10'd1000, 10'd20, 10'd10, 11'd5, 10'd1, 10'd1};
    vecs[2] = '{1'b0, mkf(16'hFFFF, 16'h0003, 16'h0007, 16'hFFFF, 16'h0402, 16'h8123), 8'h00, 1'b1,
                10'h3FF, 10'h003, 10'h007, 11'h7FF, 10'h002, 10'h123};
    vecs[3] = '{1'b1, mkf(16'd1000, 16'd20, 16'd10, 16'd5, 16'd1, 16'd1), 8'h00, 1'b1,
                10'd1000, 10'd20, 10'd10, 11'd5, 10'd1, 10'd1};
    vecs[4] = '{1'b0, mkf(16'h00A5, 16'hA5A5, 16'h0123, 16'h0456, 16'h0789, 16'h03FF), 8'h00, 1'b1,
                10'h0A5, 10'h1A5, 10'h123, 11'h456, 10'h389, 10'h3FF};
    vecs[5] = '{1'b0, mkf(16'd1000, 16'd20, 16'd10, 16'd5, 16'd1, 16'd1), 8'h80, 1'b0,
                10'h0A5, 10'h1A5, 10'h123, 11'h456, 10'h389, 10'h3FF};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outs("reset", 10'd0, 10'd0, 10'd0, 11'd0, 10'd0, 10'd0);
    chk("reset_rdy", {31'd0, in_ready}, 32'd1);
    chk("reset_pulses", {29'd0, core_start, frame_ok, frame_err}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Abort after 5 payload bytes; frame_err must rise on the TIMEOUT-th idle edge.
    fp = vecs[2].f;
    send_byte(HDR);
    for (int i = 0; i < 5; i++) begin
      w = fp[i/2];
      send_byte((i % 2 == 0) ? w[7:0] : w[15:8]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (k < 2 * TIMEOUT) begin
      @(posedge clk);
      #1;
      k++;
      if (frame_err) break;
    end
    chk("timeout_cycles", 32'(k), 32'(TIMEOUT));
    chk("timeout_start", {31'd0, core_start}, 32'd0);
    @(posedge clk);
    #1;
    chk("timeout_err_1cyc", {31'd0, frame_err}, 32'd0);
    chk_outs("timeout_hold", 10'h0A5, 10'h1A5, 10'h123, 11'h456, 10'h389, 10'h3FF);
    run_vec("after_timeout", vecs[0]);

    // Reset in the middle of payload byte 7.
    send_byte(HDR);
    for (int i = 0; i < 7; i++) send_byte(8'h5A);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outs("midrst", 10'd0, 10'd0, 10'd0, 11'd0, 10'd0, 10'd0);
    chk("midrst_rdy", {31'd0, in_ready}, 32'd1);
    run_vec("after_rst", vecs[2]);

    // Back-to-back frames: second HEADER is held off only by the APPLY cycle.
    k = starts;
    send_frame(vecs[0].f, 8'h00);
    send_frame(vecs[4].f, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_commits += 2;
    chk("b2b_starts", 32'(starts - k), 32'd2);
    chk_outs("b2b", 10'h0A5, 10'h1A5, 10'h123, 11'h456, 10'h389, 10'h3FF);

    chk("total_starts", 32'(starts), 32'(exp_commits));
    chk("ok_eq_start", 32'(oks), 32'(starts));
    chk("ready_low_cycles", 32'(lows), 32'(exp_commits));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
